// File: rtl/mips_pipe_pkg.sv
// Shared constants and types for the MIPS pipeline stages.
// Used by fetch_stage and fetch_hold_buf.
package mips_pipe_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pc_plus4;
    logic            valid;
  } if_iss_t;

  localparam if_iss_t ISS_BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding buffer for an instruction response that arrives
// while decode is stalled.
module fetch_hold_buf
  import mips_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic            drain,
  input  logic            clear,
  input  logic [PC_W-1:0] instr,
  input  logic [PC_W-1:0] pc_plus4,
  output logic            full,
  output logic [PC_W-1:0] held_instr,
  output logic [PC_W-1:0] held_pc_plus4
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (clear || drain) begin
      full <= 1'b0;
    end else if (capture) begin
      full <= 1'b1;
    end
  end

  // NOTE: payload registers are not reset; the occupancy flag alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (capture) begin
      held_instr    <= instr;
      held_pc_plus4 <= pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, IF/ISS register.
// Optional fetch-bubble counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_fetch_hz_i,
  input  logic            flush_iss_hz_i,
  input  logic            branch_taken_ex_i,
  input  logic [PC_W-1:0] branch_tgt_ex_i,
  input  logic            jump_iss_i,
  input  logic [PC_W-1:0] jump_tgt_iss_i,
  output logic            imem_req_valid_o,
  output logic [PC_W-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  logic [PC_W-1:0] imem_rsp_data_i,
  output logic [PC_W-1:0] instr_iss_o,
  output logic [PC_W-1:0] pc_plus4_iss_o,
  output logic            valid_iss_o,
  output logic [31:0]     stall_cnt_o
);

  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic            discard;
  if_iss_t         iss;

  logic            redirect;
  logic [PC_W-1:0] redirect_tgt;
  logic            rsp_fresh;
  logic            rsp_load;
  logic            rsp_capture;
  logic            buf_drain;
  logic            buf_load;
  logic            buf_clear;
  logic            req_valid;
  logic            req_accept;
  logic            buf_full;
  logic [PC_W-1:0] buf_instr;
  logic [PC_W-1:0] buf_pc_plus4;

  // The EX branch is older than the ISS jump, so it wins a same-cycle redirect.
  always_comb begin
    redirect     = branch_taken_ex_i | jump_iss_i;
    redirect_tgt = word_align(branch_taken_ex_i ? branch_tgt_ex_i : jump_tgt_iss_i);
  end

  always_comb begin
    rsp_fresh   = (state == WAIT) && imem_rsp_valid_i && !discard && !redirect;
    rsp_load    = rsp_fresh && !stall_fetch_hz_i && !flush_iss_hz_i;
    rsp_capture = rsp_fresh && stall_fetch_hz_i && !flush_iss_hz_i;
    buf_drain   = (state == HOLD) && !stall_fetch_hz_i && !redirect;
    buf_load    = buf_drain && buf_full && !flush_iss_hz_i;
    buf_clear   = (state == HOLD) && redirect;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_valid = 1'b0;
    unique case (state)
      REQ:     req_valid = !stall_fetch_hz_i;
      WAIT:    req_valid = imem_rsp_valid_i && !discard && !redirect && !stall_fetch_hz_i;
      default: req_valid = 1'b0;
    endcase
  end

  assign imem_req_valid_o = rst_n && req_valid;
  assign imem_req_addr_o  = pc;
  assign req_accept       = imem_req_valid_o && imem_req_ready_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= REQ;
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else begin
      if (redirect) begin
        pc <= redirect_tgt;
      end else if (req_accept) begin
        pc <= pc + PC_W'(4);
      end

      unique case (state)
        REQ: begin
          if (req_accept) state <= WAIT;
          // An accepted request that coincides with a redirect fetches the wrong path.
          if (req_accept && redirect) discard <= 1'b1;
        end
        WAIT: begin
          if (imem_rsp_valid_i) begin
            discard <= 1'b0;
            if (rsp_capture) begin
              state <= HOLD;
            end else if (!req_accept) begin
              state <= REQ;
            end
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect || !stall_fetch_hz_i) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  // PC already points past the fetched word while its response is pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss <= ISS_BUBBLE;
    end else if (flush_iss_hz_i) begin
      iss <= ISS_BUBBLE;
    end else if (!stall_fetch_hz_i) begin
      if (rsp_load) begin
        iss <= '{instr: imem_rsp_data_i, pc_plus4: pc, valid: 1'b1};
      end else if (buf_load) begin
        iss <= '{instr: buf_instr, pc_plus4: buf_pc_plus4, valid: 1'b1};
      end else begin
        iss <= ISS_BUBBLE;
      end
    end
  end

  assign instr_iss_o    = iss.instr;
  assign pc_plus4_iss_o = iss.pc_plus4;
  assign valid_iss_o    = iss.valid;

  fetch_hold_buf u_hold_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .capture       (rsp_capture),
    .drain         (buf_drain),
    .clear         (buf_clear),
    .instr         (imem_rsp_data_i),
    .pc_plus4      (pc),
    .full          (buf_full),
    .held_instr    (buf_instr),
    .held_pc_plus4 (buf_pc_plus4)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!iss.valid && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the PC, issues single-outstanding requests to instruction memory, and loads the IF/ISS pipeline register that feeds decode. It sits directly upstream of the hazard unit's consumers. It obeys `stall_fetch` and `flush_iss` from the hazard unit and redirects on jumps resolved in ISS and branches resolved in EX. Wrong-path responses already in flight are discarded.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `stall_fetch_hz_i`  in  1  hold PC and IF/ISS register.
- `flush_iss_hz_i`  in  1  replace IF/ISS contents with NOP.
- `branch_taken_ex_i`  in  1  EX branch redirect.
- `branch_tgt_ex_i`  in  32  branch target.
- `jump_iss_i`  in  1  ISS jump redirect.
- `jump_tgt_iss_i`  in  32  jump target.
- `imem_req_valid_o`  out  1  request valid.
- `imem_req_addr_o`  out  32  word-aligned fetch address.
- `imem_req_ready_i`  in  1  request accepted when valid & ready.
- `imem_rsp_valid_i`  in  1  response data valid; exactly one per accepted request, at least 1 cycle after acceptance.
- `imem_rsp_data_i`  in  32  instruction word.
- `instr_iss_o`  out  32  IF/ISS instruction.
- `pc_plus4_iss_o`  out  32  IF/ISS PC+4.
- `valid_iss_o`  out  1  IF/ISS holds a real instruction.
- `stall_cnt_o`  out  32  fetch-bubble counter (see Configuration).

## Operation
- Reset: PC=RESET_PC, state REQ, `imem_req_valid_o`=0 during reset, `instr_iss_o`=0, `pc_plus4_iss_o`=0, `valid_iss_o`=0, discard flag=0, hold buffer empty, `stall_cnt_o`=0. Reset mid-transaction abandons the outstanding request. A late response is ignored while `rst_n`=0. The bench/memory is also reset.
- States:
  - REQ: drive `imem_req_valid_o`=1, addr=PC. On accept, go to WAIT and set PC=PC+4.
  - WAIT: await the response.
    - Response with no stall: load IF/ISS. In the same cycle assert a request for the new PC and stay in WAIT if accepted, else go to REQ.
    - Response with stall: capture it in the hold buffer and go to HOLD.
  - HOLD: while stalled, keep the buffer. When the stall drops, load IF/ISS from the buffer and go to REQ.
- Redirect priority: `branch_taken_ex_i` (older) over `jump_iss_i`. Target bits [1:0] are forced to 00. Redirect sets PC=target and overrides the +4 increment.
  - REQ: the unaccepted request is withdrawn; the next address is the target. A request accepted in the redirect cycle is wrong-path: set the discard flag.
  - WAIT: set the discard flag. The response is dropped, then go to REQ.
  - HOLD: empty the buffer and go to REQ.
  - Redirect is not blocked by stall.
- `flush_iss_hz_i`: IF/ISS becomes instr=0, valid=0 and pc_plus4=0. This overrides stall and overrides a same-cycle response load, which is then dropped.
- `stall_fetch_hz_i` without flush: IF/ISS is unchanged, PC is unchanged and no new request is issued. An outstanding response still completes into the hold buffer.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Request accepted at cycle t with response at t+k: the instruction is visible on `*_iss_o` at t+k+1.
- When k=1 and ready is always high, throughput is 1 instruction/cycle.
- Redirect at cycle t: the first request to the target is at t+1. The first target instruction is in ISS no earlier than t+3.
- `imem_req_valid_o` may depend combinationally on `imem_rsp_valid_i`, stall, flush and redirect. All other outputs are registered.

## Configuration
- Macro: `FETCH_PERF_CNT_EN`.
  - Defined: `stall_cnt_o` increments once per cycle in which `valid_iss_o` is 0 after reset is released. It saturates at 32'hFFFF_FFFF. It clears only on reset.
  - Undefined: the counter logic is absent and `stall_cnt_o` is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `mips_pipe_pkg`:
  - `NOP_INSTR` (32'h0).
  - fetch state enum {REQ, WAIT, HOLD}.
  - `RESET_PC_DEFAULT`.
  - `PC_W`=32.
- One sub-module, `fetch_hold_buf`: a one-entry buffer with capture/release/clear controls. Instantiated once.

## Test plan
- Reset with RESET_PC=32'h100 and a k=1 memory -> requests to 0x100, 0x104, 0x108 on consecutive cycles; valid_iss rises 2 cycles after reset release.
- Stall asserted while a response arrives (data 0xDEADBEEF) -> IF/ISS unchanged during the stall; 0xDEADBEEF appears the cycle after the stall drops; no duplicate request is issued.
- Branch to 0x200 while the request to 0x108 is outstanding -> the 0x108 response is never valid in ISS; the next request is to 0x200; pc_plus4_iss=0x204.
- Same-cycle branch (0x300) and jump (0x400) -> fetch goes to 0x300 only.
- flush_iss together with a response -> valid_iss=0 and instr_iss=0; with FETCH_PERF_CNT_EN, stall_cnt increments by 1.
- PC=0xFFFF_FFFC -> next request 0x0000_0000; redirect target 0x203 -> request address 0x200.
